// File: rtl/add_pkg.sv
// add_pkg: shared widths and payload types for the adder normalization stage.
package add_pkg;
  localparam int MAN_W = 16;
  localparam int EXP_W = 8;
  localparam int CNT_W = 4;
  localparam bit CNT_BOUNDS_OK = (2 ** CNT_W) >= MAN_W;
  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic [CNT_W-1:0] cnt;
    logic             empty;
  } norm_req_t;
  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic [CNT_W-1:0] shift;
    logic             sign;
    logic             zero;
    logic             denorm;
  } norm_s1_t;
  typedef struct packed {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             denorm;
  } norm_rsp_t;
endpackage

// File: rtl/add_pipe_reg.sv
// add_pipe_reg: one valid/ready register slice with flush, generic payload.
module add_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  assign ready_o = !valid_o || ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (ready_o) begin
      valid_o <= valid_i;
      if (valid_i) data_o <= data_i;
    end
  end
endmodule

// File: rtl/add_norm_shift.sv
// add_norm_shift: two-stage normalization (decide shift/exponent, then left shift)
// with the shift clamped at the minimum exponent for gradual underflow.
module add_norm_shift
  import add_pkg::*;
#(
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [MAN_WIDTH-1:0] man_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  input  logic                 sign_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 empty_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAN_WIDTH-1:0] man_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic                 sign_o,
  output logic                 zero_o,
  output logic                 denorm_o
);
  if (2 ** CNT_WIDTH < MAN_WIDTH || !CNT_BOUNDS_OK || MAN_WIDTH != MAN_W ||
      EXP_WIDTH != EXP_W || CNT_WIDTH != CNT_W) begin : g_bad_cfg
    $error("add_norm_shift: width parameters inconsistent with add_pkg or 2**CNT_WIDTH < MAN_WIDTH");
  end
  norm_req_t req;
  norm_s1_t  s1_d, s1_q;
  norm_rsp_t s2_d, s2_q;
  logic [EXP_WIDTH-1:0] cnt_ext;
  logic exp_gt, s1_valid, s2_ready;
  assign req = '{man: man_i, exp: exp_i, sign: sign_i, cnt: cnt_i, empty: empty_i};
  assign cnt_ext = EXP_WIDTH'(req.cnt);
  assign exp_gt = req.exp > cnt_ext;
  // when exp <= cnt the shift stops one short of exp so the result lands on exp 0 (subnormal)
  always_comb begin
    s1_d.man    = req.empty ? '0 : req.man;
    s1_d.sign   = req.sign;
    s1_d.zero   = req.empty;
    s1_d.denorm = !req.empty && !exp_gt;
    s1_d.exp    = (!req.empty && exp_gt) ? req.exp - cnt_ext : '0;
    s1_d.shift  = (req.empty || req.exp == '0) ? '0 :
                  exp_gt ? req.cnt : CNT_WIDTH'(req.exp - EXP_WIDTH'(1));
  end
  add_pipe_reg #(.T(norm_s1_t)) u_s1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(s1_d),
    .valid_o(s1_valid), .ready_i(s2_ready), .data_o(s1_q)
  );
  always_comb begin
    s2_d.man    = s1_q.man << s1_q.shift;
    s2_d.exp    = s1_q.exp;
    s2_d.sign   = s1_q.sign;
    s2_d.zero   = s1_q.zero;
    s2_d.denorm = s1_q.denorm;
  end
  add_pipe_reg #(.T(norm_rsp_t)) u_s2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(s1_valid), .ready_o(s2_ready), .data_i(s2_d),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(s2_q)
  );
  assign man_o    = s2_q.man;
  assign exp_o    = s2_q.exp;
  assign sign_o   = s2_q.sign;
  assign zero_o   = s2_q.zero;
  assign denorm_o = s2_q.denorm;
endmodule

// File: doc/add_norm_shift.md
# add_norm_shift

Pipelined normalization stage for the VPE floating-point adder datapath. Consumes the raw mantissa sum together with the leading-zero count and empty flag produced by the upstream add_lzc (MODE=1), left-shifts the mantissa to restore the leading one, and adjusts the exponent. Gradual underflow is handled by clamping the shift at the minimum exponent. It is a 2-stage valid/ready pipeline placed between the adder's LZC stage and the rounding stage.

## Interface
- MAN_WIDTH, 16: mantissa width; MSB is the leading-one position after normalization
- EXP_WIDTH, 8: unsigned biased exponent width
- CNT_WIDTH, 4: leading-zero count width; must satisfy 2**CNT_WIDTH >= MAN_WIDTH

- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of both pipeline stages
- valid_i  in  1  request valid
- ready_o  out  1  stage 1 can accept
- man_i  in  MAN_WIDTH  unnormalized mantissa
- exp_i  in  EXP_WIDTH  exponent belonging to man_i
- sign_i  in  1  sign, passed through
- cnt_i  in  CNT_WIDTH  leading zeros of man_i (from add_lzc)
- empty_i  in  1  man_i is all zero (from add_lzc)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts
- man_o  out  MAN_WIDTH  normalized mantissa
- exp_o  out  EXP_WIDTH  adjusted exponent
- sign_o  out  1  sign
- zero_o  out  1  result is exact zero
- denorm_o  out  1  result is subnormal (exp_o = 0, shift clamped)

## Operation
- Stage 1 (decide), registered on accept:
  - empty_i=1: shift=0, exp=0, zero=1, denorm=0, mantissa register loaded with 0.
  - exp_i > cnt_i: shift=cnt_i, exp=exp_i-cnt_i, denorm=0.
  - exp_i <= cnt_i, exp_i != 0: shift=exp_i-1, exp=0, denorm=1.
  - exp_i == 0: shift=0, exp=0, denorm=1.
  - Arithmetic: cnt_i is zero-extended to EXP_WIDTH before compare and subtract. No wrap is possible because subtraction occurs only when exp_i > cnt_i. The shift register is CNT_WIDTH bits.
- Stage 2 (shift), registered on advance: man = man_s1 << shift_s1, logical; vacated LSBs are zero. Bits shifted out are never nonzero, because shift <= cnt_i.
- cnt_i and empty_i are trusted as given; no consistency check against man_i.
- sign_i and zero are carried unchanged through both stages.

## Timing
- Latency 2 cycles from accept (valid_i & ready_o) to valid_o; throughput 1 per cycle with no backpressure.
- Stage enable: s2_en = !valid_o | ready_i; s1_en = !s1_valid | s2_en; ready_o = s1_en (combinational from ready_i, valid_o and s1_valid).
- valid_o/data hold stable while valid_o & !ready_i; no data is dropped or duplicated under any ready_i pattern.
- Simultaneous accept and emit in the same cycle is allowed at both stages.
- flush_i: both valids cleared next edge; an input presented in the flush cycle is discarded; ready_o is 1 the cycle after.
- Reset (async assert, any time including mid-operation): s1_valid=0, valid_o=0, man_o=0, exp_o=0, sign_o=0, zero_o=0, denorm_o=0, ready_o=1. In-flight data is lost.
- Reset deassertion is synchronized externally; the first accept is possible on the first edge after release.

## Structure
- Shared package add_pkg:
  - norm_req_t: man, exp, sign, cnt, empty
  - norm_rsp_t: man, exp, sign, zero, denorm
  - localparam bounds check for CNT_WIDTH vs MAN_WIDTH
- Sub-module add_pipe_reg (generic valid/ready register slice, parameterized payload type). Instantiated twice; the decide/shift logic sits between the slices.
- Elaboration assertion: 2**CNT_WIDTH >= MAN_WIDTH.

## Test plan
- Normal: man_i=16'h0010, cnt_i=11, exp_i=20 -> after 2 cycles man_o=16'h8000, exp_o=9, denorm_o=0, zero_o=0.
- Underflow clamp: man_i=16'h0010, cnt_i=11, exp_i=5 -> man_o=16'h0100, exp_o=0, denorm_o=1; exp_i=0, cnt_i=3, man_i=16'h1234 -> man_o=16'h1234, exp_o=0, denorm_o=1.
- Zero: empty_i=1, man_i=0, exp_i=40, sign_i=1 -> man_o=0, exp_o=0, zero_o=1, sign_o=1.
- Backpressure:
  - 8 back-to-back requests with ready_i toggling pseudo-randomly -> outputs in order and stable while stalled.
  - ready_o=0 only when both stages are full and ready_i=0.
- Boundary: exp_i == cnt_i (exp_i=4, cnt_i=4, man_i=16'h0800) -> shift 3, man_o=16'h4000, exp_o=0, denorm_o=1; cnt_i=0, exp_i=1 -> unchanged mantissa, exp_o=1.
- Reset/flush mid-operation:
  - Assert rst_ni=0 with both stages full -> all outputs 0 and ready_o=1 immediately; no stale result after release.
  - flush_i with both stages full -> valid_o=0 next cycle.
